// File: rtl/pic_host_master.sv
// rtl/pic_host_master.sv - CPU-side bus master for an 8259A-style interrupt controller
// Runs ICW/OCW init, single register writes/reads and the two-pulse INTA cycle.
module pic_host_master #(
  parameter int SETUP   = 1,
  parameter int PULSE_W = 2
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       cfg_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  output logic       busy,
  output logic       init_done,
  input  logic       wr_req,
  input  logic       wr_a0,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_req,
  input  logic       rd_a0,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       INT,
  output logic       vec_valid,
  output logic [7:0] vec,
  output logic       NCS,
  output logic       NWR,
  output logic       NRD,
  output logic       NINTA,
  output logic       A0,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOV,
    S_INTA1, S_IGAP, S_INTA2, S_IRECOV
  } state_t;

  typedef enum logic [1:0] {OP_INIT, OP_WR, OP_RD} op_t;

  state_t     state;
  op_t        op;
  logic [7:0] cnt;
  logic [2:0] step;
  logic [2:0] nstep;
  logic [7:0] nbyte;
  logic       cur_a0;
  logic [7:0] cur_data;
  logic [7:0] icw2_q, icw3_q, icw4_q, ocw1_q;
  logic       sngl_q, ic4_q;
  logic       int_meta, int_s, arm;
  logic [7:0] rd_shadow;

  // Steps: 0=ICW1 1=ICW2 2=ICW3 3=ICW4 4=OCW1; ICW3 skipped in single mode, ICW4 skipped without IC4.
  always_comb begin
    nstep = 3'd4;
    case (step)
      3'd0:    nstep = 3'd1;
      3'd1:    nstep = !sngl_q ? 3'd2 : (ic4_q ? 3'd3 : 3'd4);
      3'd2:    nstep = ic4_q ? 3'd3 : 3'd4;
      default: nstep = 3'd4;
    endcase
    nbyte = ocw1_q;
    case (nstep)
      3'd1:    nbyte = icw2_q;
      3'd2:    nbyte = icw3_q;
      3'd3:    nbyte = icw4_q;
      default: nbyte = ocw1_q;
    endcase
  end

  // Pin outputs are decoded from the state held during the previous cycle,
  // so every pin change lands one edge after the state change that caused it.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state     <= S_IDLE;
      op        <= OP_INIT;
      cnt       <= '0;
      step      <= '0;
      cur_a0    <= 1'b0;
      cur_data  <= '0;
      icw2_q    <= '0;
      icw3_q    <= '0;
      icw4_q    <= '0;
      ocw1_q    <= '0;
      sngl_q    <= 1'b0;
      ic4_q     <= 1'b0;
      int_meta  <= 1'b0;
      int_s     <= 1'b0;
      arm       <= 1'b1;
      rd_shadow <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      vec_valid <= 1'b0;
      vec       <= '0;
      NCS       <= 1'b1;
      NWR       <= 1'b1;
      NRD       <= 1'b1;
      NINTA     <= 1'b1;
      A0        <= 1'b0;
      D_out     <= '0;
      D_oe      <= 1'b0;
    end else begin
      int_meta  <= INT;
      int_s     <= int_meta;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      vec_valid <= 1'b0;
      busy      <= (state != S_IDLE);
      if (!int_s) arm <= 1'b1;

      case (state)
        S_IDLE: begin
          NCS   <= 1'b1;
          NWR   <= 1'b1;
          NRD   <= 1'b1;
          NINTA <= 1'b1;
          D_oe  <= 1'b0;
          cnt   <= '0;
          if (cfg_start) begin
            op        <= OP_INIT;
            step      <= 3'd0;
            cur_a0    <= 1'b0;
            cur_data  <= icw1 | 8'h10;
            sngl_q    <= icw1[1];
            ic4_q     <= icw1[0];
            icw2_q    <= icw2;
            icw3_q    <= icw3;
            icw4_q    <= icw4;
            ocw1_q    <= ocw1;
            init_done <= 1'b0;
            state     <= S_SETUP;
          end else if (init_done && int_s && arm) begin
            arm   <= 1'b0;
            state <= S_INTA1;
          end else if (init_done && wr_req) begin
            op       <= OP_WR;
            cur_a0   <= wr_a0;
            cur_data <= wr_data;
            state    <= S_SETUP;
          end else if (init_done && rd_req) begin
            op     <= OP_RD;
            cur_a0 <= rd_a0;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          NCS   <= 1'b0;
          A0    <= cur_a0;
          D_out <= cur_data;
          D_oe  <= (op != OP_RD);
          if (cnt == 8'(SETUP - 1)) begin
            cnt   <= '0;
            state <= S_STROBE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_STROBE: begin
          NWR <= (op == OP_RD);
          NRD <= (op != OP_RD);
          if (cnt == 8'(PULSE_W - 1)) begin
            cnt   <= '0;
            state <= S_HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HOLD: begin
          // This edge closes the last strobe-low cycle on the pins.
          NWR       <= 1'b1;
          NRD       <= 1'b1;
          rd_shadow <= D_in;
          state     <= S_RECOV;
        end
        S_RECOV: begin
          NCS  <= 1'b1;
          D_oe <= 1'b0;
          if (op == OP_WR) wr_ack <= 1'b1;
          if (op == OP_RD) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_shadow;
          end
          if (op == OP_INIT && step != 3'd4) begin
            step     <= nstep;
            cur_a0   <= 1'b1;
            cur_data <= nbyte;
            state    <= S_SETUP;
          end else begin
            if (op == OP_INIT) init_done <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_INTA1, S_INTA2: begin
          NINTA <= 1'b0;
          if (cnt == 8'(PULSE_W - 1)) begin
            cnt   <= '0;
            state <= (state == S_INTA1) ? S_IGAP : S_IRECOV;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_IGAP: begin
          NINTA <= 1'b1;
          state <= S_INTA2;
        end
        S_IRECOV: begin
          NINTA     <= 1'b1;
          vec       <= D_in;
          vec_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_master.sv
// tb/tb_pic_host_master.sv - scoreboard bench for pic_host_master
// Stimulus pushes expected bus/host events; a negedge monitor pops and compares them.
module tb_pic_host_master;

  logic       CLK = 1'b0;
  logic       NRST = 1'b0;
  logic       cfg_start = 1'b0;
  logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0, ocw1 = '0;
  logic       busy, init_done;
  logic       wr_req = 1'b0, wr_a0 = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ack;
  logic       rd_req = 1'b0, rd_a0 = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       INT = 1'b0;
  logic       vec_valid;
  logic [7:0] vec;
  logic       NCS, NWR, NRD, NINTA, A0, D_oe;
  logic [7:0] D_out;
  logic [7:0] D_in = '0;

  localparam logic [1:0] K_W = 2'd0, K_A = 2'd1, K_R = 2'd2, K_V = 2'd3;

  int tests = 0;
  int errs  = 0;
  int ecount = 0;
  logic [11:0] exp_q[$];
  logic prev_nwr = 1'b1;

  pic_host_master #(.SETUP(1), .PULSE_W(2)) dut (
    .CLK(CLK), .NRST(NRST), .cfg_start(cfg_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
    .busy(busy), .init_done(init_done),
    .wr_req(wr_req), .wr_a0(wr_a0), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_a0(rd_a0), .rd_valid(rd_valid), .rd_data(rd_data),
    .INT(INT), .vec_valid(vec_valid), .vec(vec),
    .NCS(NCS), .NWR(NWR), .NRD(NRD), .NINTA(NINTA), .A0(A0),
    .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) ecount <= ecount + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Event word: {kind[1:0], a0, oe, data[7:0]}
  task automatic push(input logic [1:0] kind, input logic a0, input logic oe, input logic [7:0] data);
    exp_q.push_back({kind, a0, oe, data});
  endtask

  task automatic got(input logic [11:0] ev);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      errs++;
      $display("FAIL unexpected_event: got 0x%0h expected none", ev);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard_event", 32'(ev), 32'(e));
    end
  endtask

  always @(negedge CLK) begin
    if (NRST) begin
      if (prev_nwr && !NWR) got({K_W, A0, D_oe, D_out});
      if (wr_ack)    got({K_A, 1'b0, 1'b0, 8'h00});
      if (rd_valid)  got({K_R, 1'b0, 1'b0, rd_data});
      if (vec_valid) got({K_V, 1'b0, 1'b0, vec});
    end
    prev_nwr <= NWR;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_init(input logic [7:0] b1, b2, b3, b4, b5, input int nwr, input bit arb);
    int k;
    int n;
    icw1 = b1; icw2 = b2; icw3 = b3; icw4 = b4; ocw1 = b5;
    cfg_start = 1'b1;
    tick();
    k = ecount;
    cfg_start = 1'b0;
    tick();
    check("init_start", 32'({NCS, busy, init_done}), 32'(3'b010));
    n = 1;
    while (!init_done && n < 200) begin
      if (arb && n == 3) begin
        INT = 1'b1; D_in = 8'h31;
        wr_req = 1'b1; wr_a0 = 1'b1; wr_data = 8'h0B;
      end
      tick();
      n++;
    end
    check("init_done_edge", 32'(ecount - k), 32'(nwr * 5));
    check("init_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    logic [5:0] pat;
    logic ok;

    // Reset
    repeat (3) tick();
    check("reset_strobes", 32'({NCS, NWR, NRD, NINTA}), 32'(4'hF));
    check("reset_bus", 32'({A0, D_oe, D_out}), 32'd0);
    check("reset_status", 32'({busy, init_done, wr_ack, rd_valid, vec_valid}), 32'd0);
    check("reset_data", 32'({rd_data, vec}), 32'd0);
    NRST = 1'b1;
    tick();

    // Single-mode init: no ICW3
    push(K_W, 1'b0, 1'b1, 8'h13);
    push(K_W, 1'b1, 1'b1, 8'h20);
    push(K_W, 1'b1, 1'b1, 8'h03);
    push(K_W, 1'b1, 1'b1, 8'hF0);
    run_init(8'h13, 8'h20, 8'h55, 8'h03, 8'hF0, 4, 1'b0);
    tick();

    // INTA with the controller dropping INT during the gap
    push(K_V, 1'b0, 1'b0, 8'h24);
    c = ecount;
    INT = 1'b1;
    n = 0;
    do begin tick(); n++; end while (NINTA && n < 20);
    check("inta_latency", 32'(ecount - c), 32'd4);
    pat = '0;
    pat[0] = NINTA;
    ok = NCS;
    for (int i = 1; i < 6; i++) begin
      tick();
      pat[i] = NINTA;
      ok &= NCS;
      if (i == 2) begin INT = 1'b0; D_in = 8'h24; end
    end
    check("inta_pulses", 32'(pat), 32'(6'b100100));
    check("inta_ncs_high", 32'(ok), 32'd1);
    n = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (!NINTA) n++; end
    check("no_double_ack", 32'(n), 32'd0);

    // Second INTA after INT low then high
    push(K_V, 1'b0, 1'b0, 8'h25);
    D_in = 8'h25;
    INT = 1'b1;
    n = 0;
    do begin tick(); n++; end while (NINTA && n < 20);
    check("inta2_seen", 32'(NINTA), 32'd0);
    INT = 1'b0;
    repeat (10) tick();

    // Cascade re-init; INT and a write arrive together mid-init, INTA must win
    push(K_W, 1'b0, 1'b1, 8'h11);
    push(K_W, 1'b1, 1'b1, 8'h08);
    push(K_W, 1'b1, 1'b1, 8'h04);
    push(K_W, 1'b1, 1'b1, 8'h01);
    push(K_W, 1'b1, 1'b1, 8'h00);
    push(K_V, 1'b0, 1'b0, 8'h31);
    push(K_W, 1'b1, 1'b1, 8'h0B);
    push(K_A, 1'b0, 1'b0, 8'h00);
    run_init(8'h01, 8'h08, 8'h04, 8'h01, 8'h00, 5, 1'b1);
    n = 0;
    do begin tick(); n++; end while (NINTA && n < 20);
    check("arb_inta_first", 32'({NINTA, NCS}), 32'(2'b01));
    INT = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!wr_ack && n < 40);
    check("arb_wr_ack", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    repeat (4) tick();

    // Plain write at A0=0
    push(K_W, 1'b0, 1'b1, 8'h5A);
    push(K_A, 1'b0, 1'b0, 8'h00);
    wr_a0 = 1'b0; wr_data = 8'h5A; wr_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!wr_ack && n < 40);
    check("wr_ack_seen", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
    repeat (3) tick();

    // Status read
    push(K_R, 1'b0, 1'b0, 8'h81);
    rd_a0 = 1'b0; D_in = 8'h81; rd_req = 1'b1;
    ok = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      if (!NRD && !NCS && !D_oe && !A0 && NWR) ok = 1'b1;
    end while (!rd_valid && n < 40);
    check("rd_valid_seen", 32'(rd_valid), 32'd1);
    check("rd_strobe", 32'(ok), 32'd1);
    rd_req = 1'b0;
    repeat (3) tick();

    // Reset during STROBE: strobes released at once, no read reported
    D_in = 8'h99; rd_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (NRD && n < 40);
    check("rst_rd_strobe_low", 32'(NRD), 32'd0);
    NRST = 1'b0; rd_req = 1'b0;
    tick();
    check("rst_mid_strobe", 32'({NCS, NRD, busy, rd_valid}), 32'(4'b1100));
    check("rst_init_cleared", 32'(init_done), 32'd0);
    NRST = 1'b1;

    // Write requests are ignored until init runs again
    wr_req = 1'b1; wr_a0 = 1'b1; wr_data = 8'h77;
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (!NCS || wr_ack) n++; end
    check("wr_blocked_no_init", 32'(n), 32'd0);
    wr_req = 1'b0;
    repeat (5) tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
